// File: rtl/window_gen_3x3_stream.sv
// window_gen_3x3_stream
// Builds 3x3 neighbourhoods from a raster pixel stream. Two line buffers hold
// the previous two rows. A two-column tap register holds the older window columns.
// A window is emitted, registered, for every accepted pixel at row>=2, col>=2.
module window_gen_3x3_stream #(
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 256,
  parameter  int IMG_H  = 256,
  localparam int CW     = $clog2(IMG_W),
  localparam int RW     = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              sof,
  input  logic [DATA_W-1:0] pixel_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic [DATA_W-1:0] win9,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // lb0 holds row r-1, lb1 holds row r-2, both addressed by column
  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];

  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [RW-1:0]     row_q, row_d, cur_row;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic              emit;

  // tap_q[0] is column c-2, tap_q[1] is column c-1; inner index 0=top .. 2=bottom
  logic [DATA_W-1:0] tap_q [2][3];
  logic [DATA_W-1:0] tap_d [2][3];

  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [RW-1:0]     out_row_q, out_row_d;
  logic [CW-1:0]     out_col_q, out_col_d;

  // Position of the incoming pixel, line-buffer reads and counter advance
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    lb0_rd  = lb0_mem[cur_col];
    lb1_rd  = lb1_mem[cur_col];
    emit    = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // Tap shift and the registered window image (zero when nothing is emitted)
  always_comb begin
    tap_d        = tap_q;
    win_d        = '{default: '0};
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_row_d    = '0;
    out_col_d    = '0;
    if (in_valid) begin
      tap_d[0]    = tap_q[1];
      tap_d[1][0] = lb1_rd;
      tap_d[1][1] = lb0_rd;
      tap_d[1][2] = pixel_in;
    end
    if (emit) begin
      win_d[0]     = tap_q[0][0];
      win_d[1]     = tap_q[1][0];
      win_d[2]     = lb1_rd;
      win_d[3]     = tap_q[0][1];
      win_d[4]     = tap_q[1][1];
      win_d[5]     = lb0_rd;
      win_d[6]     = tap_q[0][2];
      win_d[7]     = tap_q[1][2];
      win_d[8]     = pixel_in;
      out_valid_d  = 1'b1;
      out_row_d    = cur_row - RW'(1);
      out_col_d    = cur_col - CW'(1);
      frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end
  end

  // Counters and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  // Unreset datapath storage: taps and line buffers (read-before-write per column)
  always_ff @(posedge clk) begin
    tap_q <= tap_d;
    if (in_valid) begin
      lb1_mem[cur_col] <= lb0_rd;
      lb0_mem[cur_col] <= pixel_in;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign win1 = win_q[0];
  assign win2 = win_q[1];
  assign win3 = win_q[2];
  assign win4 = win_q[3];
  assign win5 = win_q[4];
  assign win6 = win_q[5];
  assign win7 = win_q[6];
  assign win8 = win_q[7];
  assign win9 = win_q[8];

endmodule

// File: tb/tb_window_gen_3x3_stream.sv
// Bench for window_gen_3x3_stream at 8x6, pixel = row*8+col.
// Stimulus pushes expected windows; a negedge monitor pops and compares them.
module tb_window_gen_3x3_stream;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst, in_valid, sof;
  logic [7:0] pixel_in;
  logic       out_valid, frame_done;
  logic [7:0] win1, win2, win3, win4, win5, win6, win7, win8, win9;
  logic [2:0] out_row, out_col;

  always #5 clk = ~clk;

  window_gen_3x3_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .pixel_in(pixel_in),
    .out_valid(out_valid),
    .win1(win1), .win2(win2), .win3(win3), .win4(win4), .win5(win5),
    .win6(win6), .win7(win7), .win8(win8), .win9(win9),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [8:0][7:0] w;
    logic [2:0]      r;
    logic [2:0]      c;
    logic            fd;
  } exp_t;

  exp_t            q[$];
  exp_t            e_mon;
  logic [8:0][7:0] act_w;
  logic [8:0][7:0] first_w, w26;
  int checks = 0, errors = 0, nwin = 0, nfd = 0;
  int m_row = 0, m_col = 0;
  bit mon_en = 1'b0;
  logic acc_prev = 1'b0;

  always_comb begin
    act_w[0] = win1; act_w[1] = win2; act_w[2] = win3;
    act_w[3] = win4; act_w[4] = win5; act_w[5] = win6;
    act_w[6] = win7; act_w[7] = win8; act_w[8] = win9;
  end

  always @(posedge clk) acc_prev <= in_valid && !rst;

  // Monitor: every presented window is matched against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (acc_prev !== 1'b1) begin
          errors++;
          $display("FAIL spurious_valid: out_valid=1 without a preceding acceptance (required 0)");
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got w=%h r=%0d c=%0d, required none", act_w, out_row, out_col);
        end else begin
          e_mon = q.pop_front();
          if (act_w !== e_mon.w || out_row !== e_mon.r || out_col !== e_mon.c || frame_done !== e_mon.fd) begin
            errors++;
            $display("FAIL window: got w=%h r=%0d c=%0d fd=%b, required w=%h r=%0d c=%0d fd=%b",
                     act_w, out_row, out_col, frame_done, e_mon.w, e_mon.r, e_mon.c, e_mon.fd);
          end
        end
        nwin++;
        if (frame_done === 1'b1) nfd++;
      end else begin
        checks++;
        if (out_valid !== 1'b0 || act_w !== '0 || out_row !== '0 || out_col !== '0 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero: got v=%b w=%h r=%0d c=%0d fd=%b, required all 0",
                   out_valid, act_w, out_row, out_col, frame_done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic chk_win(input string name, input logic [8:0][7:0] req);
    checks++;
    if (out_valid !== 1'b1 || act_w !== req) begin
      errors++;
      $display("FAIL %s: got v=%b w=%h required v=1 w=%h", name, out_valid, act_w, req);
    end
  endtask

  // Accept one ramp pixel at the model position; queue its window if it has one
  task automatic send_px(input bit s);
    exp_t e;
    if (s) begin m_row = 0; m_col = 0; end
    pixel_in = 8'(m_row * W + m_col);
    sof      = s;
    in_valid = 1'b1;
    if (m_row >= 2 && m_col >= 2) begin
      for (int k = 0; k < 9; k++)
        e.w[k] = 8'((m_row - 2 + k / 3) * W + (m_col - 2 + k % 3));
      e.r  = 3'(m_row - 1);
      e.c  = 3'(m_col - 1);
      e.fd = (m_row == H - 1) && (m_col == W - 1);
      q.push_back(e);
    end
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  // Stall cycle with junk on sof/pixel_in, which must be ignored
  task automatic idle();
    in_valid = 1'b0;
    sof      = 1'($urandom_range(0, 1));
    pixel_in = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic seg_begin();
    nwin = 0;
    nfd  = 0;
  endtask

  task automatic seg_end(input string name, input int n_req, input int fd_req);
    in_valid = 1'b0;
    sof      = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk({name, "_count"}, nwin, n_req);
    chk({name, "_frame_done"}, nfd, fd_req);
    chk({name, "_drained"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    first_w = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    w26     = {8'd26, 8'd25, 8'd24, 8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8};
    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; pixel_in = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    chk("reset_valid", out_valid, 0);
    chk("reset_win", act_w, 0);
    chk("reset_rowcol", {out_row, out_col}, 0);
    chk("reset_frame_done", frame_done, 0);
    mon_en = 1'b1;

    // Continuous frame, including the row-boundary cases
    seg_begin();
    for (int i = 0; i < 48; i++) begin
      send_px(i == 0);
      if (i == 17) chk("s1_before_first", out_valid, 0);
      if (i == 18) begin
        chk_win("s1_first_window", first_w);
        chk("s1_first_row", out_row, 1);
        chk("s1_first_col", out_col, 1);
      end
      if (i == 24 || i == 25) chk("s3_row_start_silent", out_valid, 0);
      if (i == 26) chk_win("s3_wrap_window", w26);
      if (i == 46) chk("s1_not_done_early", frame_done, 0);
      if (i == 47) begin
        chk("s1_last_win9", win9, 47);
        chk("s1_last_frame_done", frame_done, 1);
      end
    end
    seg_end("s1", 24, 1);

    // Same frame with random stalls
    seg_begin();
    for (int i = 0; i < 48; i++) begin
      while ($urandom_range(0, 99) < 40) idle();
      send_px(i == 0);
    end
    seg_end("s2", 24, 1);

    // Resync: sof on the 21st pixel starts a fresh ramp
    seg_begin();
    for (int i = 0; i < 20; i++) send_px(i == 0);
    for (int i = 0; i < 48; i++) begin
      send_px(i == 0);
      if (i == 17) chk("s4_silent_before_first", out_valid, 0);
      if (i == 18) chk_win("s4_first_window", first_w);
    end
    seg_end("s4", 26, 1);

    // Reset pulse after pixel 30, then a ramp without sof
    seg_begin();
    for (int i = 0; i < 31; i++) send_px(i == 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("s5_reset_valid", out_valid, 0);
    chk("s5_reset_win", act_w, 0);
    chk("s5_reset_rowcol", {out_row, out_col}, 0);
    chk("s5_pre_reset_count", nwin, 11);
    q.delete();
    m_row = 0;
    m_col = 0;
    seg_begin();
    for (int i = 0; i < 48; i++) begin
      send_px(1'b0);
      if (i == 18) chk_win("s5_first_window", first_w);
    end
    seg_end("s5", 24, 1);

    // Two back-to-back frames, sof only on the first
    seg_begin();
    for (int i = 0; i < 96; i++) send_px(i == 0);
    seg_end("s6", 48, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3_stream.md
Name: window_gen_3x3_stream

Overview:
- Streaming, parametrised successor to the fixed 256-wide framebuffer window reader.
- Accepts a raster-order pixel stream and builds 3x3 neighbourhoods on the fly, using two internal line buffers instead of a full-frame memory.
- Emits one valid-only window per qualifying input pixel, with center coordinates, to the downstream 3x3 filter stage.
- Supports any image size, data width, input gaps, frame resync and a frame-done marker.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 256, pixels per line; must be >= 3.
- IMG_H, 256, lines per frame; must be >= 3.
- CW, $clog2(IMG_W), column counter width (derived, not overridden).
- RW, $clog2(IMG_H), row counter width (derived, not overridden).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  pixel_in is valid this cycle.
- sof  in  1  start of frame; qualified by in_valid.
- pixel_in  in  DATA_W  raster-order input pixel.
- out_valid  out  1  window outputs are valid this cycle.
- win1..win9  out  DATA_W each  window, row-major: win1 top-left, win3 top-right, win7 bottom-left, win9 bottom-right.
- out_row  out  RW  center row of the current window.
- out_col  out  CW  center column of the current window.
- frame_done  out  1  one-cycle pulse coinciding with the last window of a frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - col, row counters clear to 0.
  - out_valid, frame_done, win1..win9, out_row, out_col all clear to 0.
  - Line-buffer and shift-register contents are not reset; they are don't-care because output is gated until row>=2 and col>=2.
- Acceptance: a pixel is accepted on any edge with in_valid=1. in_valid=0 cycles are stalls, and all state holds.
- Position of an accepted pixel:
  - If sof=1, the pixel is position (0,0); counters are forced accordingly.
  - Otherwise the pixel is at the current (row,col).
- Counter advance after each acceptance:
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0, so an implicit next frame follows.
  - sof with in_valid=0 is ignored.
- Line buffers:
  - lb0 holds row r-1 and lb1 holds row r-2, each IMG_W x DATA_W, addressed by col.
  - On acceptance at column c: read lb1[c] and lb0[c], then write lb1[c] <= lb0[c] and lb0[c] <= pixel_in in the same edge (read-before-write).
- Window register: 3x3 array shifted left by one column per acceptance. The new right column is {lb1[c], lb0[c], pixel_in}, top to bottom.
- Output, registered, latency 1:
  - On the edge after accepting pixel (r,c) with r>=2 and c>=2: out_valid=1.
  - The window covers rows r-2..r and columns c-2..c; win9 = that pixel.
  - out_row = r-1, out_col = c-1.
- When the edge has no qualifying acceptance: out_valid=0, and win1..win9, out_row, out_col are driven to 0.
- frame_done=1 exactly when out_valid=1 with out_row=IMG_H-2 and out_col=IMG_W-2; 0 otherwise.
- Windows never straddle lines: columns 0 and 1 of each row produce no output, so stale left columns are flushed.
- Window count is (IMG_H-2)*(IMG_W-2) per frame.
- Resync on sof mid-frame: the partial frame is abandoned. No output appears until the new frame's (2,2).
- Reset mid-frame:
  - Outputs are 0 in the next cycle.
  - The next accepted pixel is (0,0).
  - Nothing pending is emitted afterwards.
- Arithmetic: counters compare against IMG_W-1 and IMG_H-1 exactly. There is no pixel arithmetic; data passes through bit-exact.

Test Plan:
(All scenarios: IMG_W=8, IMG_H=6, DATA_W=8, pixel = row*8+col.)
1. Continuous frame with sof on the first pixel:
   - First out_valid occurs 1 cycle after pixel 18 is accepted, with win1..win9 = 0,1,2,8,9,10,16,17,18 and out_row=1, out_col=1.
   - Exactly 24 windows are emitted.
   - The last window has win9=47 and frame_done=1 only on that cycle.
2. Same frame with random in_valid gaps (about 40% idle) -> identical window sequence. out_valid is never high on a cycle not preceded by an acceptance.
3. Row boundary -> no out_valid for accepted pixels 24 and 25 (col 0,1). The pixel-26 window is 8,9,10,16,17,18,24,25,26.
4. sof asserted on the 21st pixel, then a fresh ramp from 0 -> no output until the new pixel 18. The window then equals scenario 1's first window.
5. rst pulsed for 1 cycle after pixel 30:
   - Outputs are 0 the next cycle.
   - A fresh ramp without sof reproduces scenario 1 output exactly.
6. Two back-to-back frames with no sof on the second -> the second frame yields the same 24 windows as the first, with frame_done pulsing twice.
